// File: rtl/ycfsm_token_driver_if.sv
// Host handshake, result and cell-rail bundle for the ycfsm token driver.
// The master side is the host plus the asynchronous cell. The slave side is the driver.
interface ycfsm_token_driver_if;
    logic       s_valid;
    logic       s_ready;
    logic       s_bit;
    logic       s_match;
    logic       s_clear;
    logic       r_valid;
    logic [1:0] r_out;
    logic       r_timeout;
    logic       r_illegal;
    logic       err;
    logic       y_reset;
    logic [1:0] y_in;
    logic [1:0] y_match;
    logic [1:0] y_out;

    modport master (
        output s_valid, s_bit, s_match, s_clear, y_out,
        input  s_ready, r_valid, r_out, r_timeout, r_illegal, err,
        input  y_reset, y_in, y_match
    );

    modport slave (
        input  s_valid, s_bit, s_match, s_clear, y_out,
        output s_ready, r_valid, r_out, r_timeout, r_illegal, err,
        output y_reset, y_in, y_match
    );
endinterface

// File: rtl/ycfsm_token_driver.sv
// Clocked four-phase driver: places one host token on the ycfsm in/match rails and waits for the cell output.
// It then returns the rails to empty and reports the captured code, with timeout and illegal-code detection.
module ycfsm_token_driver #(
    parameter int TIMEOUT  = 255,
    parameter int CW       = 8,
    parameter int RST_HOLD = 4
) (
    input logic             clk,
    input logic             reset,
    ycfsm_token_driver_if.slave bus
);
    typedef enum logic [2:0] {CLEAR, IDLE, DRIVE, RELEASE, ERROR} state_t;

    localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CW-1:0] TMO       = CW'(TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    function automatic logic [1:0] enc(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    state_t        state;
    logic [CW-1:0] timer;
    logic [HW-1:0] hold;
    logic [1:0]    s1, s2, q;
    logic          stable;

    // Agreement between s2 and q filters out any y_out pulse that lasts only one cycle.
    assign stable = (s2 == q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CLEAR;
            hold          <= '0;
            timer         <= '0;
            s1            <= 2'b00;
            s2            <= 2'b00;
            q             <= 2'b00;
            bus.y_reset   <= 1'b1;
            bus.y_in      <= 2'b00;
            bus.y_match   <= 2'b00;
            bus.s_ready   <= 1'b0;
            bus.r_valid   <= 1'b0;
            bus.r_out     <= 2'b00;
            bus.r_timeout <= 1'b0;
            bus.r_illegal <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            s1          <= bus.y_out;
            s2          <= s1;
            q           <= s2;
            bus.r_valid <= 1'b0;

            if (bus.s_clear) begin
                // A clear request aborts any transaction in progress and overrides a token offered in the same cycle.
                state       <= CLEAR;
                hold        <= '0;
                timer       <= '0;
                bus.y_reset <= 1'b1;
                bus.y_in    <= 2'b00;
                bus.y_match <= 2'b00;
                bus.s_ready <= 1'b0;
                bus.err     <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        if (hold == HOLD_LAST) begin
                            state       <= IDLE;
                            bus.y_reset <= 1'b0;
                            bus.s_ready <= 1'b1;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end
                    IDLE: begin
                        if (bus.s_valid && bus.s_ready) begin
                            state         <= DRIVE;
                            bus.y_in      <= enc(bus.s_bit);
                            bus.y_match   <= enc(bus.s_match);
                            bus.s_ready   <= 1'b0;
                            bus.r_timeout <= 1'b0;
                            bus.r_illegal <= 1'b0;
                            timer         <= '0;
                        end
                    end
                    DRIVE: begin
                        if (stable && (s2 != 2'b00)) begin
                            state         <= RELEASE;
                            bus.r_out     <= s2;
                            bus.r_illegal <= (s2 == 2'b11);
                            bus.y_in      <= 2'b00;
                            bus.y_match   <= 2'b00;
                            timer         <= '0;
                        end else if (timer == TMO) begin
                            state         <= RELEASE;
                            bus.r_out     <= 2'b00;
                            bus.r_timeout <= 1'b1;
                            bus.y_in      <= 2'b00;
                            bus.y_match   <= 2'b00;
                            timer         <= '0;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                    RELEASE: begin
                        if (stable && (s2 == 2'b00)) begin
                            state       <= IDLE;
                            bus.r_valid <= 1'b1;
                            bus.s_ready <= 1'b1;
                        end else if (timer == TMO) begin
                            state   <= ERROR;
                            bus.err <= 1'b1;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end
                    ERROR: begin
                        bus.s_ready <= 1'b0;
                        bus.y_in    <= 2'b00;
                        bus.y_match <= 2'b00;
                    end
                    default: begin
                        state <= CLEAR;
                        hold  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ycfsm_token_driver.sv
// Self-checking bench for ycfsm_token_driver. A stub cell echoes y_in after 3 ns, or the bench forces y_out by hand.
// Expected results are queued when a token is accepted and compared when r_valid fires.
module tb_ycfsm_token_driver;
    typedef struct packed {
        logic [1:0] out;
        logic       to;
        logic       il;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [1:0] echo     = 2'b00;
    logic [1:0] echo_nxt = 2'b00;
    logic       manual   = 1'b0;
    logic [1:0] man_val  = 2'b00;

    ycfsm_token_driver_if bus ();

    ycfsm_token_driver #(.TIMEOUT(255), .CW(8), .RST_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(bus.y_in) begin
        echo_nxt = bus.y_in;
        #3 echo = echo_nxt;
    end
    assign bus.y_out = manual ? man_val : echo;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] enc_tb(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic m, output logic ok);
        int n;
        n = 0;
        bus.s_bit   = b;
        bus.s_match = m;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 50) begin
            tick();
            n++;
        end
        ok = bus.s_ready;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_rvalid(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.r_valid && n < lim);
        if (!bus.r_valid) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.s_valid = 1'b0; bus.s_bit = 1'b0; bus.s_match = 1'b0; bus.s_clear = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.y_reset, bus.s_ready, bus.y_in, bus.y_match, bus.r_valid, bus.r_out,
             bus.r_timeout, bus.r_illegal, bus.err} !== 12'b1000_0000_0000) begin
            errors++;
            $display("FAIL reset_state: got yr=%b rdy=%b yin=%b ym=%b rv=%b ro=%b to=%b il=%b err=%b required 1 0 00 00 0 00 0 0 0",
                     bus.y_reset, bus.s_ready, bus.y_in, bus.y_match, bus.r_valid, bus.r_out,
                     bus.r_timeout, bus.r_illegal, bus.err);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.y_reset !== 1'b1 || bus.s_ready !== 1'b0) begin
                errors++;
                $display("FAIL clear_hold[%0d]: got y_reset=%b s_ready=%b required 1 0", i, bus.y_reset, bus.s_ready);
            end
        end
        tick();
        checks++;
        if (bus.y_reset !== 1'b0 || bus.s_ready !== 1'b1 || bus.y_in !== 2'b00 || bus.y_match !== 2'b00) begin
            errors++;
            $display("FAIL clear_exit: got y_reset=%b s_ready=%b y_in=%b y_match=%b required 0 1 00 00",
                     bus.y_reset, bus.s_ready, bus.y_in, bus.y_match);
        end
    endtask

    task automatic test_single();
        logic ok;
        int   n;
        exp_t e;
        manual = 1'b0;
        send(1'b1, 1'b1, ok);
        sb.push_back({2'b10, 1'b0, 1'b0});
        checks++;
        if (!ok || bus.y_in !== 2'b10 || bus.y_match !== 2'b10 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_drive: got ok=%b y_in=%b y_match=%b s_ready=%b required 1 10 10 0",
                     ok, bus.y_in, bus.y_match, bus.s_ready);
        end
        tick(); tick(); tick();
        checks++;
        if (bus.y_in !== 2'b10) begin
            errors++;
            $display("FAIL single_hold_n3: got y_in=%b required 10", bus.y_in);
        end
        tick();
        checks++;
        if (bus.y_in !== 2'b00 || bus.y_match !== 2'b00) begin
            errors++;
            $display("FAIL single_release_n4: got y_in=%b y_match=%b required 00 00", bus.y_in, bus.y_match);
        end
        wait_rvalid(20, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles after release required 4", n);
        end
        if (n > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.r_out !== e.out || bus.r_timeout !== e.to || bus.r_illegal !== e.il || bus.s_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_result: got r_out=%b to=%b il=%b rdy=%b required %b %b %b 1",
                         bus.r_out, bus.r_timeout, bus.r_illegal, bus.s_ready, e.out, e.to, e.il);
            end
        end
        tick();
        checks++;
        if (bus.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got r_valid=%b required 0", bus.r_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] bits;
        int         acc[3];
        int         k;
        int         got;
        logic       accepting;
        exp_t       e;
        bits = 3'b010;
        k = 0;
        got = 0;
        manual = 1'b0;
        bus.s_bit = bits[0]; bus.s_match = ~bits[0]; bus.s_valid = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            accepting = bus.s_valid && bus.s_ready;
            tick();
            if (accepting) begin
                acc[k] = c;
                sb.push_back({enc_tb(bits[k]), 1'b0, 1'b0});
                checks++;
                if (bus.y_in !== enc_tb(bits[k]) || bus.y_match !== enc_tb(~bits[k])) begin
                    errors++;
                    $display("FAIL b2b_rails[%0d]: got y_in=%b y_match=%b required %b %b",
                             k, bus.y_in, bus.y_match, enc_tb(bits[k]), enc_tb(~bits[k]));
                end
                if (k > 0) begin
                    checks++;
                    if (acc[k] - acc[k-1] !== 9) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles required 9", k, acc[k] - acc[k-1]);
                    end
                end
                k++;
                if (k == 3) bus.s_valid = 1'b0;
                else begin
                    bus.s_bit = bits[k];
                    bus.s_match = ~bits[k];
                end
            end
            if (bus.r_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got r_valid with empty scoreboard required none");
                end else begin
                    e = sb.pop_front();
                    if (bus.r_out !== e.out || bus.r_timeout !== 1'b0 || bus.r_illegal !== 1'b0 || bus.y_in !== 2'b00) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got r_out=%b to=%b il=%b y_in=%b required %b 0 0 00",
                                 got, bus.r_out, bus.r_timeout, bus.r_illegal, bus.y_in, e.out);
                    end
                end
                got++;
            end
        end
        bus.s_valid = 1'b0;
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 3", got);
        end
    endtask

    task automatic test_drive_timeout();
        logic ok;
        int   n;
        exp_t e;
        manual = 1'b1;
        man_val = 2'b00;
        send(1'b1, 1'b0, ok);
        sb.push_back({2'b00, 1'b1, 1'b0});
        for (int i = 0; i < 255; i++) tick();
        checks++;
        if (!ok || bus.y_in !== 2'b10) begin
            errors++;
            $display("FAIL tmo_still_driving: got ok=%b y_in=%b required 1 10", ok, bus.y_in);
        end
        tick();
        checks++;
        if (bus.y_in !== 2'b00 || bus.y_match !== 2'b00 || bus.r_timeout !== 1'b1) begin
            errors++;
            $display("FAIL tmo_drop: got y_in=%b y_match=%b r_timeout=%b required 00 00 1",
                     bus.y_in, bus.y_match, bus.r_timeout);
        end
        wait_rvalid(20, n);
        checks++;
        if (n !== 1 || sb.size() == 0) begin
            errors++;
            $display("FAIL tmo_rvalid: got %0d cycles required 1", n);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.r_out !== e.out || bus.r_timeout !== e.to || bus.r_illegal !== e.il) begin
                errors++;
                $display("FAIL tmo_result: got r_out=%b to=%b il=%b required %b %b %b",
                         bus.r_out, bus.r_timeout, bus.r_illegal, e.out, e.to, e.il);
            end
        end
    endtask

    task automatic test_release_error();
        logic ok;
        int   n;
        int   rv;
        manual = 1'b1;
        man_val = 2'b00;
        send(1'b0, 1'b0, ok);
        checks++;
        if (!ok || bus.r_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_accept_clears: got ok=%b r_timeout=%b required 1 0", ok, bus.r_timeout);
        end
        man_val = 2'b10;
        n = 0;
        rv = 0;
        while (!bus.err && n < 400) begin
            tick();
            n++;
            if (bus.r_valid) rv++;
        end
        checks++;
        if (bus.err !== 1'b1 || n !== 260 || rv !== 0 || bus.s_ready !== 1'b0 || bus.y_in !== 2'b00) begin
            errors++;
            $display("FAIL err_release_timeout: got err=%b cycles=%0d rvalids=%0d rdy=%b y_in=%b required 1 260 0 0 00",
                     bus.err, n, rv, bus.s_ready, bus.y_in);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.err !== 1'b1 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: got err=%b s_ready=%b required 1 0", bus.err, bus.s_ready);
        end
        manual = 1'b0;
        bus.s_clear = 1'b1;
        tick();
        bus.s_clear = 1'b0;
        checks++;
        if (bus.y_reset !== 1'b1 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got y_reset=%b err=%b required 1 0", bus.y_reset, bus.err);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.y_reset !== 1'b1) begin
                errors++;
                $display("FAIL err_clear_hold[%0d]: got y_reset=%b required 1", i, bus.y_reset);
            end
        end
        tick();
        checks++;
        if (bus.y_reset !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_idle: got y_reset=%b s_ready=%b required 0 1", bus.y_reset, bus.s_ready);
        end
    endtask

    task automatic test_illegal_glitch();
        logic ok;
        int   n;
        exp_t e;
        manual = 1'b1;
        man_val = 2'b00;
        send(1'b1, 1'b0, ok);
        sb.push_back({2'b11, 1'b0, 1'b1});
        tick(); tick();
        man_val = 2'b01;
        tick();
        man_val = 2'b00;
        tick(); tick(); tick();
        checks++;
        if (!ok || bus.y_in !== 2'b10) begin
            errors++;
            $display("FAIL glitch_ignored: got ok=%b y_in=%b required 1 10", ok, bus.y_in);
        end
        man_val = 2'b11;
        n = 0;
        while (bus.y_in !== 2'b00 && n < 20) begin
            tick();
            n++;
        end
        man_val = 2'b00;
        wait_rvalid(20, n);
        checks++;
        if (n < 0 || sb.size() == 0) begin
            errors++;
            $display("FAIL ill_rvalid: got no r_valid within budget required one");
        end else begin
            e = sb.pop_front();
            if (bus.r_out !== e.out || bus.r_timeout !== e.to || bus.r_illegal !== e.il) begin
                errors++;
                $display("FAIL ill_result: got r_out=%b to=%b il=%b required %b %b %b",
                         bus.r_out, bus.r_timeout, bus.r_illegal, e.out, e.to, e.il);
            end
        end
    endtask

    task automatic test_abort();
        logic ok;
        int   rv;
        manual = 1'b0;
        tick();
        send(1'b0, 1'b1, ok);
        bus.s_clear = 1'b1;
        tick();
        bus.s_clear = 1'b0;
        checks++;
        if (!ok || bus.y_in !== 2'b00 || bus.y_match !== 2'b00 || bus.y_reset !== 1'b1 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got ok=%b y_in=%b y_match=%b y_reset=%b s_ready=%b required 1 00 00 1 0",
                     ok, bus.y_in, bus.y_match, bus.y_reset, bus.s_ready);
        end
        rv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.r_valid) rv++;
        end
        checks++;
        if (rv !== 0 || bus.s_ready !== 1'b1 || bus.y_reset !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_rvalid: got rvalids=%0d s_ready=%b y_reset=%b required 0 1 0", rv, bus.s_ready, bus.y_reset);
        end
        bus.s_valid = 1'b1;
        bus.s_bit = 1'b1;
        bus.s_clear = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_clear = 1'b0;
        checks++;
        if (bus.y_in !== 2'b00 || bus.y_reset !== 1'b1 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins: got y_in=%b y_reset=%b s_ready=%b required 00 1 0", bus.y_in, bus.y_reset, bus.s_ready);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.s_ready !== 1'b1 || bus.r_valid !== 1'b0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL final_idle: got s_ready=%b r_valid=%b pending=%0d required 1 0 0", bus.s_ready, bus.r_valid, sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_bit = 1'b0;
        bus.s_match = 1'b0;
        bus.s_clear = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_drive_timeout();
        test_release_error();
        test_illegal_glitch();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
